// File: rtl/pktfifo_arb_pkg.sv
// Shared types and defaults for the packet-FIFO BytePipe scheduler.
package pktfifo_arb_pkg;

  // Scheduler states: wait for a request, emit the header byte, stream the body.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_BODY = 2'd2
  } state_t;

  // Upper five bits of every header byte; the low three carry the pair index.
  localparam logic [4:0] HDR_TAG_DEFAULT = 5'b10100;

  // Width of pair indices (grant, last grant); covers up to 8 pairs.
  localparam int unsigned GRANT_W = 3;

endpackage

// File: rtl/pktfifo_arb_rr_pick.sv
// Combinational round-robin picker: lowest-ranked requester after last_grant.
module rr_pick
  import pktfifo_arb_pkg::*;
#(
  parameter int unsigned N_PAIR = 2
) (
  input  logic [N_PAIR-1:0]  req,
  input  logic [GRANT_W-1:0] last_grant,
  output logic [GRANT_W-1:0] grant,
  output logic               any
);

  logic [31:0] start_idx;
  logic [31:0] rank;
  logic [31:0] best_rank;

  assign any = |req;

  // Rank each pair by its distance from last_grant+1 (mod N_PAIR); the smallest rank wins.
  always_comb begin
    start_idx = (32'(last_grant) + 32'd1) % N_PAIR;
    best_rank = N_PAIR;
    rank      = '0;
    grant     = '0;
    for (int unsigned i = 0; i < N_PAIR; i++) begin
      rank = (i + N_PAIR - start_idx) % N_PAIR;
      if (req[i] && (rank < best_rank)) begin
        best_rank = rank;
        grant     = GRANT_W'(i);
      end
    end
  end

endmodule

// File: rtl/pktfifo_arb.sv
// Round-robin scheduler draining whole packets from N_PAIR FIFOs onto one BytePipe.
module pktfifo_arb
  import pktfifo_arb_pkg::*;
#(
  parameter int unsigned N_PAIR  = 2,
  parameter int unsigned PKT_LEN = 8,
  parameter logic [4:0]  HDR_TAG = HDR_TAG_DEFAULT
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_cg,
  input  logic [N_PAIR-1:0]     i_enMask,
  input  logic [N_PAIR*8-1:0]   i_pktfifo_data,
  input  logic [N_PAIR-1:0]     i_pktfifo_empty,
  output logic [N_PAIR-1:0]     o_pktfifo_pop,
  output logic [7:0]            o_bp_data,
  output logic                  o_bp_valid,
  input  logic                  i_bp_ready,
  output logic                  o_busy,
  output logic [2:0]            o_grant
);

  localparam int unsigned       CW       = $clog2(PKT_LEN + 1);
  localparam logic [CW-1:0]     CNT_LAST = CW'(PKT_LEN - 1);
  localparam logic [GRANT_W-1:0] LAST_RST = GRANT_W'(N_PAIR - 1);

  state_t               state;
  logic [GRANT_W-1:0]   grant;
  logic [GRANT_W-1:0]   last_grant;
  logic [CW-1:0]        cnt;

  logic [N_PAIR-1:0]    req;
  logic [GRANT_W-1:0]   pick_grant;
  logic                 pick_any;
  logic [7:0]           head_data;
  logic                 head_empty;
  logic                 accept;

  assign req = i_enMask & ~i_pktfifo_empty;

  rr_pick #(
    .N_PAIR(N_PAIR)
  ) u_rr_pick (
    .req        (req),
    .last_grant (last_grant),
    .grant      (pick_grant),
    .any        (pick_any)
  );

  // Mux the granted FIFO's head byte and empty flag.
  always_comb begin
    head_data  = '0;
    head_empty = 1'b1;
    for (int unsigned i = 0; i < N_PAIR; i++) begin
      if (grant == GRANT_W'(i)) begin
        head_data  = i_pktfifo_data[i*8 +: 8];
        head_empty = i_pktfifo_empty[i];
      end
    end
  end

  // BytePipe data/valid follow the state directly so data is held while stalled.
  always_comb begin
    o_bp_valid = 1'b0;
    o_bp_data  = '0;
    case (state)
      ST_HDR: begin
        o_bp_valid = 1'b1;
        o_bp_data  = {HDR_TAG, grant};
      end
      ST_BODY: begin
        o_bp_valid = ~head_empty;
        o_bp_data  = head_data;
      end
      default: ;
    endcase
  end

  assign accept = o_bp_valid & i_bp_ready & i_cg;

  // One-hot pop of the granted FIFO on each accepted body byte.
  always_comb begin
    o_pktfifo_pop = '0;
    for (int unsigned i = 0; i < N_PAIR; i++) begin
      o_pktfifo_pop[i] = (state == ST_BODY) && accept && (grant == GRANT_W'(i));
    end
  end

  assign o_busy  = (state != ST_IDLE);
  assign o_grant = grant;

  // Scheduler state; everything holds while the clock gate is low.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      grant      <= '0;
      last_grant <= LAST_RST;
      cnt        <= '0;
    end else if (i_cg) begin
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            grant <= pick_grant;
            state <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (accept) begin
            cnt   <= '0;
            state <= ST_BODY;
          end
        end
        ST_BODY: begin
          if (accept) begin
            cnt <= cnt + CW'(1);
            if (cnt == CNT_LAST) begin
              last_grant <= grant;
              state      <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
